// File: rtl/get_bit_pkg.sv
// ---------------------------------------------------------------------------
// get_bit_pkg
//
// Purpose:
//   Shared bitstream package for the bit reader (get_bit) and the bit writer
//   (set_bit). It holds the buffer geometry, derived field widths, the
//   per-cycle buffer operation encoding and a small helper that maps the
//   requested read width onto the width actually applied.
//
// Contents:
//   BUF_W   - width of the left-aligned bit buffer (64)
//   MAX_RD  - widest field a single read may return (32)
//   BYTE_W  - width of one stream byte (8)
//   LVL_W   - width of the buffer level counter (holds 0..BUF_W)
//   SIZE_W  - width of the read size request (holds 0..MAX_RD and beyond)
//   CNT_W   - width of the consumed-bit counter
//   op_e    - buffer operation chosen for the current cycle
//   eff_size- read width after illegal sizes are folded to zero
// ---------------------------------------------------------------------------
package get_bit_pkg;

    localparam int unsigned BUF_W  = 64;
    localparam int unsigned MAX_RD = 32;
    localparam int unsigned BYTE_W = 8;

    localparam int unsigned LVL_W  = 7;
    localparam int unsigned SIZE_W = 6;
    localparam int unsigned CNT_W  = 35;

    // Operation applied to the buffer head in one cycle. A byte push is
    // orthogonal and may accompany OP_IDLE, OP_READ or OP_ALIGN.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_ALIGN = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    // Sizes above MAX_RD are not legal; they behave as a zero-width read.
    function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] size);
        if (size > SIZE_W'(MAX_RD)) begin
            return '0;
        end
        return size;
    endfunction

endpackage

// File: rtl/get_bit_extract.sv
// ---------------------------------------------------------------------------
// get_bit_extract
//
// Purpose:
//   Combinational left-aligned field extractor. Returns the top i_size bits
//   of the buffer, right-aligned and zero-extended to MAX_RD bits.
//
// Ports:
//   i_buf  [BUF_W-1:0]  - left-aligned bit buffer, first bit at the MSB
//   i_size [SIZE_W-1:0] - field width, 0..MAX_RD (0 returns zero)
//   o_val  [MAX_RD-1:0] - extracted field, right-aligned
// ---------------------------------------------------------------------------
module get_bit_extract
    import get_bit_pkg::*;
(
    input  logic [BUF_W-1:0]  i_buf,
    input  logic [SIZE_W-1:0] i_size,
    output logic [MAX_RD-1:0] o_val
);

    logic [MAX_RD-1:0] w_top;
    logic [SIZE_W-1:0] w_shift;

    // Only the upper MAX_RD bits can ever be part of a field.
    assign w_top = i_buf[BUF_W-1 -: MAX_RD];

    always_comb begin
        o_val   = '0;
        w_shift = SIZE_W'(MAX_RD) - i_size;
        // A zero-width field would need a full-width shift; handle explicitly.
        if (i_size != '0) begin
            o_val = w_top >> w_shift;
        end
    end

endmodule

// File: rtl/get_bit.sv
// ---------------------------------------------------------------------------
// get_bit
//
// Purpose:
//   Byte-fed bitstream reader. Bytes are appended behind the valid bits of a
//   64-bit left-aligned buffer; fields of 0..32 bits are read from the head.
//   An align request discards the partial byte at the head. A running count
//   of consumed bits is kept; its byte part is reported on total_byte_size.
//
// Ports:
//   clock           in   1  rising-edge clock
//   reset_n         in   1  asynchronous active-low reset
//   clear           in   1  synchronous discard of buffer and counters
//   in_valid        in   1  in_byte is valid
//   in_byte         in   8  stream byte, bit 7 first
//   in_ready        out  1  byte accepted when in_valid && in_ready
//   rd_req          in   1  field read request
//   rd_size         in   6  field width 0..32 (larger reads as zero width)
//   rd_ready        out  1  read accepted when rd_req && rd_ready
//   align           in   1  drop bits up to the next byte boundary
//   rd_ack          out  1  registered pulse, rd_val valid
//   rd_val          out 32  field value, right-aligned, zero-extended
//   level           out  7  buffered bit count, 0..64
//   total_byte_size out 32  whole bytes consumed (consumed bits >> 3)
// ---------------------------------------------------------------------------
module get_bit
    import get_bit_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_byte,
    output logic                in_ready,
    input  logic                rd_req,
    input  logic [SIZE_W-1:0]   rd_size,
    output logic                rd_ready,
    input  logic                align,
    output logic                rd_ack,
    output logic [MAX_RD-1:0]   rd_val,
    output logic [LVL_W-1:0]    level,
    output logic [31:0]         total_byte_size
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [BUF_W-1:0]   r_buf;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_consumed;
    logic               r_rd_ack;
    logic [MAX_RD-1:0]  r_rd_val;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    logic [SIZE_W-1:0]  w_size;
    logic [LVL_W-1:0]   w_size_lvl;
    logic [2:0]         w_drop;
    logic               w_push;
    logic               w_rd;
    op_e                w_op;
    logic [MAX_RD-1:0]  w_field;
    logic [BUF_W-1:0]   w_byte_lane;
    logic [BUF_W-1:0]   w_buf_mid;
    logic [LVL_W-1:0]   w_level_mid;
    logic [BUF_W-1:0]   w_buf_nxt;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [CNT_W-1:0]   w_consumed_nxt;

    assign w_size     = eff_size(rd_size);
    assign w_size_lvl = LVL_W'(w_size);
    assign w_drop     = r_level[2:0];

    // Handshakes depend only on registered state and the request inputs.
    assign in_ready = (r_level <= LVL_W'(BUF_W - BYTE_W)) && !clear;
    assign rd_ready = (r_level >= w_size_lvl) && !align && !clear;

    assign w_push = in_valid && in_ready;
    assign w_rd   = rd_req && rd_ready;

    // Head operation priority: clear, then align, then read.
    always_comb begin
        w_op = OP_IDLE;
        if (clear) begin
            w_op = OP_CLEAR;
        end else if (align) begin
            w_op = OP_ALIGN;
        end else if (w_rd) begin
            w_op = OP_READ;
        end
    end

    get_bit_extract u_extract (
        .i_buf  (r_buf),
        .i_size (w_size),
        .o_val  (w_field)
    );

    assign w_byte_lane = {in_byte, {(BUF_W-BYTE_W){1'b0}}};

    // Head operation first, then the push lands behind the bits that remain.
    // in_ready was judged on the pre-read level, so the post-head level is
    // at most 56 and the byte always fits.
    always_comb begin
        w_buf_mid      = r_buf;
        w_level_mid    = r_level;
        w_consumed_nxt = r_consumed;

        case (w_op)
            OP_READ: begin
                w_buf_mid      = r_buf << w_size;
                w_level_mid    = r_level - w_size_lvl;
                w_consumed_nxt = r_consumed + CNT_W'(w_size);
            end
            OP_ALIGN: begin
                w_buf_mid      = r_buf << w_drop;
                w_level_mid    = {r_level[LVL_W-1:3], 3'b000};
                w_consumed_nxt = r_consumed + CNT_W'(w_drop);
            end
            default: begin
            end
        endcase

        w_buf_nxt   = w_buf_mid;
        w_level_nxt = w_level_mid;
        if (w_push) begin
            w_buf_nxt   = w_buf_mid | (w_byte_lane >> w_level_mid);
            w_level_nxt = w_level_mid + LVL_W'(BYTE_W);
        end

        if (w_op == OP_CLEAR) begin
            w_buf_nxt      = '0;
            w_level_nxt    = '0;
            w_consumed_nxt = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= '0;
            r_level    <= '0;
            r_consumed <= '0;
            r_rd_ack   <= 1'b0;
            r_rd_val   <= '0;
        end else begin
            r_buf      <= w_buf_nxt;
            r_level    <= w_level_nxt;
            r_consumed <= w_consumed_nxt;
            r_rd_ack   <= (w_op == OP_READ);
            if (w_op == OP_READ) begin
                r_rd_val <= w_field;
            end
        end
    end

    assign rd_ack          = r_rd_ack;
    assign rd_val          = r_rd_val;
    assign level           = r_level;
    assign total_byte_size = r_consumed[CNT_W-1:3];

endmodule

// File: tb/tb_get_bit.sv
module tb_get_bit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        rd_req;
    logic [5:0]  rd_size;
    logic        rd_ready;
    logic        align;
    logic        rd_ack;
    logic [31:0] rd_val;
    logic [6:0]  level;
    logic [31:0] total_byte_size;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    get_bit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_byte         (in_byte),
        .in_ready        (in_ready),
        .rd_req          (rd_req),
        .rd_size         (rd_size),
        .rd_ready        (rd_ready),
        .align           (align),
        .rd_ack          (rd_ack),
        .rd_val          (rd_val),
        .level           (level),
        .total_byte_size (total_byte_size)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        #1;
        chk("push_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] n, input logic [31:0] exp, input string tag);
        rd_req  = 1'b1;
        rd_size = n;
        #1;
        chk({tag, "_ready"}, rd_ready, 1);
        step();
        rd_req = 1'b0;
        chk({tag, "_ack"}, rd_ack, 1);
        chk({tag, "_val"}, rd_val, exp);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_byte  = '0;
        rd_req   = 1'b0;
        rd_size  = '0;
        align    = 1'b0;
        step();
        step();

        // reset state
        chk("rst_level", level, 0);
        chk("rst_ack", rd_ack, 0);
        chk("rst_val", rd_val, 0);
        chk("rst_total", total_byte_size, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rd_ready_size0", rd_ready, 1);
        rd_size = 6'd5;
        #1;
        chk("rst_rd_ready_size5", rd_ready, 0);
        rd_size = '0;
        reset_n = 1'b1;
        step();

        // A5 3C read 3,5,4,4
        push(8'hA5);
        push(8'h3C);
        chk("t31_level16", level, 16);
        rd(6'd3, 32'h5, "t31_r3");
        rd(6'd5, 32'h05, "t31_r5");
        rd(6'd4, 32'h3, "t31_r4a");
        rd(6'd4, 32'hC, "t31_r4b");
        chk("t31_level", level, 0);
        chk("t31_total", total_byte_size, 2);
        step();
        chk("t31_ack_drop", rd_ack, 0);
        chk("t31_val_hold", rd_val, 32'hC);

        // 32-bit read waits for the fourth byte
        push(8'h11);
        push(8'h22);
        push(8'h33);
        rd_req  = 1'b1;
        rd_size = 6'd32;
        #1;
        chk("t32_not_ready", rd_ready, 0);
        in_valid = 1'b1;
        in_byte  = 8'h44;
        step();
        in_valid = 1'b0;
        chk("t32_no_ack", rd_ack, 0);
        chk("t32_level32", level, 32);
        chk("t32_ready", rd_ready, 1);
        step();
        rd_req = 1'b0;
        chk("t32_ack", rd_ack, 1);
        chk("t32_val", rd_val, 32'h11223344);
        chk("t32_level0", level, 0);
        chk("t32_total", total_byte_size, 6);

        // full buffer, read and refused push in the same cycle
        for (int unsigned i = 1; i <= 8; i++) begin
            push(8'(i));
        end
        chk("t33_level64", level, 64);
        chk("t33_in_ready0", in_ready, 0);
        rd_req   = 1'b1;
        rd_size  = 6'd8;
        in_valid = 1'b1;
        in_byte  = 8'h99;
        #1;
        chk("t33_push_refused", in_ready, 0);
        chk("t33_rd_ready", rd_ready, 1);
        step();
        rd_req   = 1'b0;
        in_valid = 1'b0;
        chk("t33_ack", rd_ack, 1);
        chk("t33_val", rd_val, 32'h01);
        chk("t33_level56", level, 56);
        chk("t33_in_ready1", in_ready, 1);
        rd(6'd32, 32'h02030405, "t33_r32");
        rd(6'd24, 32'h00060708, "t33_r24");
        chk("t33_level0", level, 0);
        chk("t33_total", total_byte_size, 14);

        // align after a partial read; align beats a same-cycle read
        push(8'hFF);
        push(8'h81);
        rd(6'd3, 32'h7, "t34_r3");
        chk("t34_level13", level, 13);
        align   = 1'b1;
        rd_req  = 1'b1;
        rd_size = 6'd3;
        #1;
        chk("t34_align_blocks_rd", rd_ready, 0);
        step();
        align  = 1'b0;
        rd_req = 1'b0;
        chk("t34_align_no_ack", rd_ack, 0);
        chk("t34_level8", level, 8);
        rd(6'd8, 32'h81, "t34_r8");
        chk("t34_total", total_byte_size, 16);

        // zero-width read on empty buffer, then clear mid-stream
        rd(6'd0, 32'h0, "t35_r0");
        chk("t35_level0", level, 0);
        chk("t35_total_r0", total_byte_size, 16);
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        rd(6'd4, 32'hA, "t35_r4");
        chk("t35_level20", level, 20);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hEE;
        rd_req   = 1'b1;
        rd_size  = 6'd4;
        #1;
        chk("t35_clr_in_ready", in_ready, 0);
        chk("t35_clr_rd_ready", rd_ready, 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        chk("t35_clr_level", level, 0);
        chk("t35_clr_total", total_byte_size, 0);
        chk("t35_clr_ack", rd_ack, 0);

        // illegal size reads as zero width
        push(8'h5A);
        rd(6'd40, 32'h0, "ill_r40");
        chk("ill_level8", level, 8);
        rd(6'd8, 32'h5A, "ill_r8");
        chk("ill_total", total_byte_size, 1);

        // align with a same-cycle push
        push(8'hF0);
        rd(6'd3, 32'h7, "ap_r3");
        align    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h3C;
        #1;
        chk("ap_in_ready", in_ready, 1);
        step();
        align    = 1'b0;
        in_valid = 1'b0;
        chk("ap_level8", level, 8);
        rd(6'd8, 32'h3C, "ap_r8");
        chk("ap_total", total_byte_size, 3);

        // asynchronous reset mid-stream with a read pending
        push(8'hDE);
        push(8'hAD);
        rd(6'd3, 32'h6, "t36_r3");
        chk("t36_level13", level, 13);
        rd_req  = 1'b1;
        rd_size = 6'd4;
        #1;
        reset_n = 1'b0;
        #1;
        chk("t36_level", level, 0);
        chk("t36_ack", rd_ack, 0);
        chk("t36_val", rd_val, 0);
        chk("t36_total", total_byte_size, 0);
        step();
        chk("t36_ack_edge", rd_ack, 0);
        rd_req  = 1'b0;
        reset_n = 1'b1;
        step();
        push(8'h77);
        rd(6'd8, 32'h77, "t36_first");
        chk("t36_total_after", total_byte_size, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
